stack_pointer_unit: RTL and testbench

//  Owns the architectural stack pointer and sequences stack memory accesses for PUSH/POP/CALL/RET/INT/RTI.

---
 rtl/stack_pointer_unit.sv | 188 ++++++++++++++++++
 tb/tb_stack_pointer_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// Architectural stack pointer plus the word sequencer for PUSH/POP/CALL/RET/INT/RTI.
// Multi-word ops issue one stack access per cycle; SP tracks each word and rolls back on flush.
module stack_pointer_unit #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_0FFF,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    output logic        op_ready,
    input  logic        flush,
    output logic [31:0] SP_VALUE,
    output logic        Stack_OP,
    output logic [31:0] acc_addr,
    output logic        acc_write,
    output logic [1:0]  acc_idx,
    output logic        done,
    output logic        ovf_err,
    output logic        unf_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_INT  = 3'd5;
    localparam logic [2:0] OP_RTI  = 3'd6;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [1:0]  widx, widx_nxt;
    logic        is_push, is_push_nxt;
    logic [31:0] sp, sp_nxt;
    logic [31:0] sp_old, sp_old_nxt;

    logic        stack_op_nxt;
    logic [31:0] acc_addr_nxt;
    logic        acc_write_nxt;
    logic [1:0]  acc_idx_nxt;
    logic        done_nxt;
    logic        ovf_nxt, unf_nxt;

    // request decode: word count and direction
    logic [1:0]  req_words;
    logic        req_push;

    always_comb begin
        req_words = 2'd0;
        req_push  = 1'b0;
        case (op_code)
            OP_PUSH: begin req_words = 2'd1; req_push = 1'b1; end
            OP_POP:  begin req_words = 2'd1; req_push = 1'b0; end
            OP_CALL: begin req_words = 2'd2; req_push = 1'b1; end
            OP_RET:  begin req_words = 2'd2; req_push = 1'b0; end
            OP_INT:  begin req_words = 2'd3; req_push = 1'b1; end
            OP_RTI:  begin req_words = 2'd3; req_push = 1'b0; end
            default: begin req_words = 2'd0; req_push = 1'b0; end
        endcase
    end

    // bounds checked one bit wider so the comparison cannot wrap
    logic [32:0] push_low, pop_high;
    logic        req_illegal;

    always_comb begin
        push_low    = {1'b0, sp} - {31'd0, req_words} + 33'd1;
        pop_high    = {1'b0, sp} + {31'd0, req_words};
        req_illegal = req_push ? (push_low < {1'b0, STACK_LIMIT})
                               : (pop_high > {1'b0, STACK_BASE});
    end

    assign op_ready = (state == IDLE) & ~flush;
    assign SP_VALUE = sp;

    logic        issue;
    logic        w_push;
    logic [31:0] w_base;
    logic [1:0]  w_k;
    logic        w_last;
    logic [31:0] w_k32;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        widx_nxt      = widx;
        is_push_nxt   = is_push;
        sp_nxt        = sp;
        sp_old_nxt    = sp_old;
        stack_op_nxt  = 1'b0;
        acc_addr_nxt  = acc_addr;
        acc_write_nxt = 1'b0;
        acc_idx_nxt   = 2'd0;
        done_nxt      = 1'b0;
        ovf_nxt       = ovf_err;
        unf_nxt       = unf_err;
        issue         = 1'b0;
        w_push        = is_push;
        w_base        = sp_old;
        w_k           = widx + 2'd1;
        w_last        = (cnt == 2'd1);

        case (state)
            IDLE: begin
                if (op_valid && op_ready && req_words != 2'd0) begin
                    if (req_illegal) begin
                        done_nxt = 1'b1;
                        if (req_push) ovf_nxt = 1'b1;
                        else          unf_nxt = 1'b1;
                    end else begin
                        state_nxt   = ISSUE;
                        cnt_nxt     = req_words - 2'd1;
                        widx_nxt    = 2'd0;
                        sp_old_nxt  = sp;
                        is_push_nxt = req_push;
                        issue       = 1'b1;
                        w_push      = req_push;
                        w_base      = sp;
                        w_k         = 2'd0;
                        w_last      = (req_words == 2'd1);
                    end
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_nxt = IDLE;
                    sp_nxt    = sp_old;
                end else if (cnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt - 2'd1;
                    widx_nxt = widx + 2'd1;
                    issue    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        w_k32 = {30'd0, w_k};
        if (issue) begin
            stack_op_nxt  = 1'b1;
            acc_write_nxt = w_push;
            acc_idx_nxt   = w_k;
            done_nxt      = w_last;
            // push writes at the pre-decrement SP; pop reads at the post-increment SP
            acc_addr_nxt  = w_push ? (w_base - w_k32) : (w_base + w_k32 + 32'd1);
            sp_nxt        = w_push ? (w_base - w_k32 - 32'd1) : (w_base + w_k32 + 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            widx      <= 2'd0;
            is_push   <= 1'b0;
            sp        <= STACK_BASE;
            sp_old    <= STACK_BASE;
            Stack_OP  <= 1'b0;
            acc_addr  <= 32'd0;
            acc_write <= 1'b0;
            acc_idx   <= 2'd0;
            done      <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            widx      <= widx_nxt;
            is_push   <= is_push_nxt;
            sp        <= sp_nxt;
            sp_old    <= sp_old_nxt;
            Stack_OP  <= stack_op_nxt;
            acc_addr  <= acc_addr_nxt;
            acc_write <= acc_write_nxt;
            acc_idx   <= acc_idx_nxt;
            done      <= done_nxt;
            ovf_err   <= ovf_nxt;
            unf_err   <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an op-level model (word lists planned at accept).
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_ready;
    logic        flush;
    logic [31:0] SP_VALUE;
    logic        Stack_OP;
    logic [31:0] acc_addr;
    logic        acc_write;
    logic [1:0]  acc_idx;
    logic        done;
    logic        ovf_err;
    logic        unf_err;

    int total = 0;
    int bad   = 0;

    stack_pointer_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_ready (op_ready),
        .flush    (flush),
        .SP_VALUE (SP_VALUE),
        .Stack_OP (Stack_OP),
        .acc_addr (acc_addr),
        .acc_write(acc_write),
        .acc_idx  (acc_idx),
        .done     (done),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  idx;
        logic        last;
        logic [31:0] sp_after;
    } word_t;

    word_t       wq[$];
    word_t       w;
    logic        m_live = 1'b0;
    logic [31:0] e_sp, e_sp_old, e_addr;
    logic        e_stack_op, e_write, e_done, e_ovf, e_unf;
    logic [1:0]  e_idx;
    int          n;
    logic        is_push;

    always @(posedge clk) begin
        if (!rst_n) begin
            wq.delete();
            m_live = 1'b1;
            e_sp = 32'hFFF; e_sp_old = 32'hFFF; e_addr = 0;
            e_stack_op = 0; e_write = 0; e_idx = 0; e_done = 0; e_ovf = 0; e_unf = 0;
        end else if (m_live) begin
            logic busy;
            busy = e_stack_op;
            e_stack_op = 0; e_write = 0; e_idx = 0; e_done = 0;
            if (busy) begin
                if (flush) begin
                    e_sp = e_sp_old;
                    wq.delete();
                end else if (wq.size() > 0) begin
                    w = wq.pop_front();
                    e_stack_op = 1; e_addr = w.addr; e_write = w.wr;
                    e_idx = w.idx; e_done = w.last; e_sp = w.sp_after;
                end
            end else if (op_valid && !flush && op_code >= 3'd1 && op_code <= 3'd6) begin
                n       = (op_code + 1) / 2;      // 1,2 -> 1; 3,4 -> 2; 5,6 -> 3
                is_push = op_code[0];             // PUSH/CALL/INT are odd codes
                if (is_push ? (longint'(e_sp) - n + 1 < 64'h800) : (longint'(e_sp) + n > 64'hFFF)) begin
                    e_done = 1;
                    if (is_push) e_ovf = 1; else e_unf = 1;
                end else begin
                    e_sp_old = e_sp;
                    for (int k = 0; k < n; k++) begin
                        w.wr       = is_push;
                        w.idx      = 2'(k);
                        w.last     = (k == n - 1);
                        w.addr     = is_push ? e_sp - 32'(k) : e_sp + 32'(k) + 1;
                        w.sp_after = is_push ? e_sp - 32'(k) - 1 : e_sp + 32'(k) + 1;
                        wq.push_back(w);
                    end
                    w = wq.pop_front();
                    e_stack_op = 1; e_addr = w.addr; e_write = w.wr;
                    e_idx = w.idx; e_done = w.last; e_sp = w.sp_after;
                end
            end
        end
    end

    // compare every cycle once a reset edge has been seen
    always @(negedge clk) begin
        if (m_live) begin
            check("SP_VALUE", SP_VALUE, e_sp);
            check("Stack_OP", {31'd0, Stack_OP}, {31'd0, e_stack_op});
            check("acc_addr", acc_addr, e_addr);
            check("acc_write", {31'd0, acc_write}, {31'd0, e_write});
            check("acc_idx", {30'd0, acc_idx}, {30'd0, e_idx});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("ovf_err", {31'd0, ovf_err}, {31'd0, e_ovf});
            check("unf_err", {31'd0, unf_err}, {31'd0, e_unf});
            check("op_ready", {31'd0, op_ready}, {31'd0, (!e_stack_op && !flush)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] code);
        op_valid = 1'b1; op_code = code;
        step();
        op_valid = 1'b0; op_code = 3'd0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic random_phase(input int cycles, input bit allow_reset);
        for (int i = 0; i < cycles; i++) begin
            step();
            op_valid = 1'($urandom_range(0, 1));
            op_code  = 3'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 11) == 0);
            rst_n    = allow_reset ? ($urandom_range(0, 299) != 0) : 1'b1;
        end
        step();
        op_valid = 0; op_code = 0; flush = 0; rst_n = 1;
        repeat (4) step();
    endtask

    initial begin
        rst_n = 0; op_valid = 0; op_code = 0; flush = 0;
        repeat (2) step();
        rst_n = 1; #1;
        check("rst SP", SP_VALUE, 32'hFFF);
        check("rst Stack_OP", {31'd0, Stack_OP}, 0);
        check("rst errs", {30'd0, ovf_err, unf_err}, 0);
        check("rst ready", {31'd0, op_ready}, 1);

        // single push at the base
        issue(3'd1);
        check("push op", {31'd0, Stack_OP}, 1);
        check("push addr", acc_addr, 32'hFFF);
        check("push wr/done", {30'd0, acc_write, done}, 3);
        check("push SP", SP_VALUE, 32'hFFE);
        step(); #1;
        check("push ready", {31'd0, op_ready}, 1);

        // CALL: two writes, ready held low for both
        issue(3'd3);
        check("call w0 addr", acc_addr, 32'hFFE);
        check("call w0 idx/done/rdy", {29'd0, acc_idx, done, op_ready}, 0);
        step(); #1;
        check("call w1 addr", acc_addr, 32'hFFD);
        check("call w1 idx/done/rdy", {29'd0, acc_idx, done, op_ready}, 32'b0110);
        check("call SP", SP_VALUE, 32'hFFC);
        step(); #1;
        check("call end", {30'd0, Stack_OP, op_ready}, 1);

        // underflow at the base, then a push still works
        do_reset();
        issue(3'd2);
        check("unf op/done", {30'd0, Stack_OP, done}, 1);
        check("unf flag", {31'd0, unf_err}, 1);
        check("unf SP", SP_VALUE, 32'hFFF);
        step();
        issue(3'd1);
        check("post-unf push", {30'd0, Stack_OP, unf_err}, 3);
        check("post-unf SP", SP_VALUE, 32'hFFE);

        // RTI flushed after word 0 rolls SP back
        step(); issue(3'd1); step(); issue(3'd1); step();
        check("pre-rti SP", SP_VALUE, 32'hFFC);
        issue(3'd6);
        check("rti w0", {31'd0, Stack_OP}, 1);
        check("rti w0 addr", acc_addr, 32'hFFD);
        check("rti w0 wr", {31'd0, acc_write}, 0);
        flush = 1; #1;
        check("flush ready", {31'd0, op_ready}, 0);
        step(); flush = 0; #1;
        check("flush op/done", {30'd0, Stack_OP, done}, 0);
        check("flush SP", SP_VALUE, 32'hFFC);
        step(); #1;
        check("flush idle", {30'd0, Stack_OP, done}, 0);

        // reset during CALL word 0
        issue(3'd3);
        check("call w0", {31'd0, Stack_OP}, 1);
        do_reset();
        check("rst mid op", {30'd0, Stack_OP, op_ready}, 1);
        check("rst mid SP", SP_VALUE, 32'hFFF);

        random_phase(1500, 1'b1);

        // walk down to 0x801, then INT overflows
        do_reset();
        for (int i = 0; i < 2046; i++) begin
            issue(3'd1);
            step();
        end
        check("walk SP", SP_VALUE, 32'h801);
        issue(3'd5);
        check("int ovf op/done", {30'd0, Stack_OP, done}, 1);
        check("int ovf flag", {31'd0, ovf_err}, 1);
        check("int ovf SP", SP_VALUE, 32'h801);
        step();
        issue(3'd3);
        step(); #1;
        check("call to limit SP", SP_VALUE, 32'h7FF);
        step();
        issue(3'd1);
        check("push below limit", {30'd0, Stack_OP, done}, 1);
        check("push below SP", SP_VALUE, 32'h7FF);

        random_phase(1500, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
